// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and
// the sizing rule for the bit counter.
package serial_adder_pkg;

    // Controller states; encodings are fixed so that debug tooling and
    // downstream decode can rely on them.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit counter width: enough to count 0..width-1, never less than one bit
    // so that the WIDTH=1 build still has a real register.
    function automatic int cnt_width(input int width);
        if (width > 1) begin
            return $clog2(width);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/serial_adder_fa_1bit.sv
// Single-bit full adder used as the only arithmetic element of the
// bit-serial adder. Purely combinational.
module fa_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_s;

    assign half_s = a ^ b;
    assign s      = half_s ^ cin;
    assign cout   = (a & b) | (cin & half_s);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: {cout,sum} = a + b + cin, processed LSB first,
// one bit per clock through a single full adder. A start request in IDLE or
// DONE captures the operands; WIDTH ADD cycles later the result is published
// on sum/cout together with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               fa_s;
    logic               fa_cout;
    logic [WIDTH-1:0]   psum_shift_s;

    // The one and only adder slice: current operand LSBs plus the running carry.
    fa_1bit u_fa (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Partial sum after this cycle's bit lands in the MSB; after WIDTH shifts
    // bit i holds the i-th serial result.
    always_comb begin
        psum_shift_s            = psum_q >> 1;
        psum_shift_s[WIDTH-1]   = fa_s;
    end

    // Next-state and datapath control for the IDLE/ADD/DONE controller.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        psum_d  = psum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_ADD;
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = cin;
                    psum_d  = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                // start and operand inputs are deliberately ignored here.
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                carry_d = fa_cout;
                psum_d  = psum_shift_s;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    // Publish only the finished word so partials never leak.
                    state_d = ST_DONE;
                    sum_d   = psum_shift_s;
                    cout_d  = fa_cout;
                end else begin
                    state_d = ST_ADD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state of the adder; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            psum_q  <= psum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_ADD);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: a WIDTH=8 and a WIDTH=1 instance,
// directed corner cases plus randomized operands checked against a + b + cin.
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int pass_cnt;
    int chk_cnt;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation with a single-cycle start. glitch_at >= 1 re-pulses
    // start (with a=FF) that many cycles after acceptance; it must be ignored.
    task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                           input int glitch_at, input string tag);
        logic [8:0] exp;
        logic [7:0] prev_sum;
        logic       prev_cout;
        int         cycles;
        int         busy_cycles;
        int         leak;
        exp       = 9'(av) + 9'(bv) + 9'(cv);
        prev_sum  = sum8;
        prev_cout = cout8;
        leak      = 0;
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        cycles = 0;
        busy_cycles = 0;
        while (!done8 && cycles < 40) begin
            if (busy8) busy_cycles++;
            if (sum8 !== prev_sum || cout8 !== prev_cout) leak = 1;
            @(posedge clk); #1;
            cycles++;
            if (cycles == glitch_at) begin
                start8 = 1'b1;
                a8     = 8'hFF;
            end else begin
                start8 = 1'b0;
            end
        end
        check_eq({tag, " latency"}, 32'(cycles), 32'd8);
        check_eq({tag, " busy_cycles"}, 32'(busy_cycles), 32'd8);
        check_eq({tag, " no_partial"}, 32'(leak), 32'd0);
        check_eq({tag, " sum"}, 32'(sum8), 32'(exp[7:0]));
        check_eq({tag, " cout"}, 32'(cout8), 32'(exp[8]));
        @(posedge clk); #1;
        check_eq({tag, " done_pulse"}, 32'(done8), 32'd0);
        check_eq({tag, " idle_busy"}, 32'(busy8), 32'd0);
        check_eq({tag, " sum_hold"}, 32'(sum8), 32'(exp[7:0]));
    endtask

    // One WIDTH=1 operation.
    task automatic run_op1(input logic av, input logic bv, input logic cv, input string tag);
        logic [1:0] exp;
        int         cycles;
        exp = 2'(av) + 2'(bv) + 2'(cv);
        @(negedge clk);
        a1 = av; b1 = bv; cin1 = cv; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cycles = 0;
        while (!done1 && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        check_eq({tag, " latency"}, 32'(cycles), 32'd1);
        check_eq({tag, " sum_cout"}, 32'({cout1, sum1}), 32'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        int         cycles;
        int         dones;
        logic [7:0] ra, rb;
        logic       rc;
        pass_cnt = 0;
        chk_cnt  = 0;
        rst = 1'b1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        #2;
        check_eq("reset busy", 32'(busy8), 32'd0);
        check_eq("reset done", 32'(done8), 32'd0);
        check_eq("reset sum", 32'(sum8), 32'd0);
        check_eq("reset cout", 32'(cout8), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op8(8'hFF, 8'h01, 1'b0, -1, "ff_plus_01");
        run_op8(8'h5A, 8'hA5, 1'b1, -1, "5a_a5_c1");
        run_op8(8'h00, 8'h00, 1'b0, -1, "zeros");
        run_op8(8'h12, 8'h34, 1'b0, 3, "start_ignored");

        // Reset in the middle of an operation.
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst busy", 32'(busy8), 32'd0);
        check_eq("midrst done", 32'(done8), 32'd0);
        check_eq("midrst sum", 32'(sum8), 32'd0);
        check_eq("midrst cout", 32'(cout8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8) dones++;
        end
        check_eq("midrst no_done", 32'(dones), 32'd0);
        run_op8(8'h80, 8'h80, 1'b0, -1, "after_rst");

        // Back-to-back: start held high through DONE.
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1;
        cycles = 0;
        while (!done8 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        check_eq("b2b first latency", 32'(cycles), 32'd8);
        check_eq("b2b first sum", 32'(sum8), 32'h02);
        check_eq("b2b first cout", 32'(cout8), 32'd0);
        @(posedge clk); #1;
        start8 = 1'b0;
        check_eq("b2b reload busy", 32'(busy8), 32'd1);
        cycles = 1;
        while (!done8 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        check_eq("b2b spacing", 32'(cycles), 32'd9);
        check_eq("b2b second sum", 32'(sum8), 32'h00);
        check_eq("b2b second cout", 32'(cout8), 32'd1);
        @(posedge clk); #1;

        // Randomized operands, occasionally with an ignored mid-op start.
        for (int n = 0; n < 20; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            run_op8(ra, rb, rc, ((n % 4) == 0) ? int'($urandom_range(1, 7)) : -1, "random");
        end

        // WIDTH=1: every operand combination.
        for (int k = 0; k < 8; k++) begin
            run_op1(k[2], k[1], k[0], "w1_combo");
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
